// File: rtl/multifunction_barrel_shifter_pipe.sv
// Pipelined ROR/ROL/LSR/ASR barrel shifter, one register stage per amount bit, valid/ready on both sides.
// Optional zero/carry flag outputs are enabled by defining BARREL_SHIFTER_FLAGS_EN.
module multifunction_barrel_shifter_pipe #(
   parameter int DATA_W = 8,
   parameter int AMT_W  = 3
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] a,
   input  logic [AMT_W-1:0]  amt,
   input  logic [1:0]        mode,
   output logic              y_valid,
   input  logic              y_ready,
   output logic [DATA_W-1:0] y,
   output logic              busy
`ifdef BARREL_SHIFTER_FLAGS_EN
   ,
   output logic              zero_flag,
   output logic              carry_flag
`endif
);

   localparam logic [1:0] MODE_ROR = 2'b00;
   localparam logic [1:0] MODE_ROL = 2'b01;
   localparam logic [1:0] MODE_LSR = 2'b10;

   if ((DATA_W < 2) || ((1 << AMT_W) != DATA_W)) begin : g_param_check
      $error("multifunction_barrel_shifter_pipe: AMT_W must equal log2(DATA_W), DATA_W >= 2");
   end

   logic             advance;
   logic [AMT_W-1:0] vld_pipe;

   // Global stall: every stage moves together, bubbles are kept.
   assign advance  = ~y_valid | y_ready;
   assign in_ready = advance;

   for (genvar k = 0; k < AMT_W; k++) begin : g_st
      localparam int SH = 1 << k;

      logic              vld_i, sign_i;
      logic [DATA_W-1:0] data_i, data_n;
      logic [AMT_W-1:0]  amt_i;
      logic [1:0]        mode_i;
      logic              vld_q, sign_q;
      logic [DATA_W-1:0] data_q;
      logic [AMT_W-1:0]  amt_q;
      logic [1:0]        mode_q;
`ifdef BARREL_SHIFTER_FLAGS_EN
      logic              carry_i, carry_n, carry_q;
`endif

      if (k == 0) begin : g_src
         assign vld_i  = in_valid;
         assign data_i = a;
         assign amt_i  = amt;
         assign mode_i = mode;
         assign sign_i = a[DATA_W-1];
`ifdef BARREL_SHIFTER_FLAGS_EN
         assign carry_i = 1'b0;
`endif
      end else begin : g_link
         assign vld_i  = g_st[k-1].vld_q;
         assign data_i = g_st[k-1].data_q;
         assign amt_i  = g_st[k-1].amt_q;
         assign mode_i = g_st[k-1].mode_q;
         assign sign_i = g_st[k-1].sign_q;
`ifdef BARREL_SHIFTER_FLAGS_EN
         assign carry_i = g_st[k-1].carry_q;
`endif
      end

      // ASR fills from the carried original sign, not from the current MSB.
      always_comb begin
         data_n = data_i;
         if (amt_i[k]) begin
            case (mode_i)
               MODE_ROR: data_n = (data_i >> SH) | (data_i << (DATA_W - SH));
               MODE_ROL: data_n = (data_i << SH) | (data_i >> (DATA_W - SH));
               MODE_LSR: data_n = data_i >> SH;
               default:  data_n = (data_i >> SH) | (sign_i ? ~({DATA_W{1'b1}} >> SH) : '0);
            endcase
         end
      end

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            vld_q  <= 1'b0;
            data_q <= '0;
            amt_q  <= '0;
            mode_q <= '0;
            sign_q <= 1'b0;
         end else if (advance) begin
            vld_q  <= vld_i;
            data_q <= data_n;
            amt_q  <= amt_i;
            mode_q <= mode_i;
            sign_q <= sign_i;
         end
      end

`ifdef BARREL_SHIFTER_FLAGS_EN
      // Last bit leaving the word at this step; the final active step wins.
      always_comb begin
         carry_n = carry_i;
         if (amt_i[k])
            carry_n = (mode_i == MODE_ROL) ? data_i[DATA_W-SH] : data_i[SH-1];
      end

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n)
            carry_q <= 1'b0;
         else if (advance)
            carry_q <= carry_n;
      end
`endif

      assign vld_pipe[k] = vld_q;

      logic unused_ok;
      assign unused_ok = ^{amt_q, mode_q, sign_q};
   end

   assign y       = g_st[AMT_W-1].data_q;
   assign y_valid = vld_pipe[AMT_W-1];
   assign busy    = |vld_pipe;

`ifdef BARREL_SHIFTER_FLAGS_EN
   logic zero_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         zero_q <= 1'b0;
      else if (advance)
         zero_q <= (g_st[AMT_W-1].data_n == '0);
   end

   assign zero_flag  = zero_q;
   assign carry_flag = g_st[AMT_W-1].carry_q;
`endif

endmodule
